// File: rtl/if_fetch.sv
// Byte-serial instruction fetch: issues four byte reads per instruction over an
// 8-bit memory port, assembles them little-endian and hands them to decode.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump,
    input  logic [31:0] jump_addr,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic [7:0]  mem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        id_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [2:0]  iss;
    logic [2:0]  cap;
    logic        pend;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic        granted;

    // Address and request depend only on registered state, never on mem_gnt,
    // so a denied request is re-presented unchanged on the next cycle.
    always_comb begin
        mem_req  = (state == FETCH) && (iss < 3'd4);
        mem_addr = pc + {29'd0, iss};
        granted  = mem_req && mem_gnt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            iss        <= 3'd0;
            cap        <= 3'd0;
            pend       <= 1'b0;
            inst_valid <= 1'b0;
            inst       <= 32'h0;
            inst_pc    <= 32'h0;
        end else if (jump) begin
            // Redirect wins over everything, including a same-cycle accept;
            // clearing pend drops whatever byte is still in flight.
            state      <= FETCH;
            pc         <= jump_addr;
            iss        <= 3'd0;
            cap        <= 3'd0;
            pend       <= 1'b0;
            inst_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= FETCH;
                    iss   <= 3'd0;
                    cap   <= 3'd0;
                    pend  <= 1'b0;
                end
                FETCH: begin
                    pend <= granted;
                    if (granted) begin
                        iss <= iss + 3'd1;
                    end
                    if (pend) begin
                        cap <= cap + 3'd1;
                        // Last byte goes straight into inst; no need to buffer it.
                        if (cap == 3'd3) begin
                            state      <= HOLD;
                            inst_valid <= 1'b1;
                            inst       <= {mem_rdata, b2, b1, b0};
                            inst_pc    <= pc;
                        end
                    end
                end
                HOLD: begin
                    if (inst_valid && id_ready) begin
                        state      <= FETCH;
                        pc         <= pc + 32'd4;
                        iss        <= 3'd0;
                        cap        <= 3'd0;
                        inst_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Byte buffer carries data only, so it needs no reset.
    always_ff @(posedge clk) begin
        if ((state == FETCH) && pend && !jump) begin
            case (cap)
                3'd0:    b0 <= mem_rdata;
                3'd1:    b1 <= mem_rdata;
                3'd2:    b2 <= mem_rdata;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: a byte-addressed memory responder plus a transaction-level
// reference model (instruction = memory word at pc) checked every cycle.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump;
    logic [31:0] jump_addr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic [7:0]  mem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        id_ready;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    if_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .jump       (jump),
        .jump_addr  (jump_addr),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rdata  (mem_rdata),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .id_ready   (id_ready)
    );

    // Reference model: 0 = idle, 1 = fetching, 2 = holding an instruction.
    int          m_state;
    int          m_ng;
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_inst;
    logic [31:0] m_inst_pc;

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [31:0] t;
        case (a)
            32'd0: return 8'h13;
            32'd1: return 8'h05;
            32'd2: return 8'h10;
            32'd3: return 8'h00;
            default: begin
                t = a * 32'h9E37_79B1;
                return t[31:24] ^ t[7:0];
            end
        endcase
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] p);
        return {mem_byte(p + 32'd3), mem_byte(p + 32'd2), mem_byte(p + 32'd1), mem_byte(p)};
    endfunction

    function automatic logic [97:0] obs();
        return {mem_req, mem_req ? mem_addr : 32'h0, inst_valid,
                inst_valid ? inst : 32'h0, inst_valid ? inst_pc : 32'h0};
    endfunction

    function automatic logic [97:0] expv();
        logic r;
        r = (m_state == 1) && (m_ng < 4);
        return {r, r ? (m_pc + 32'(m_ng)) : 32'h0, m_valid,
                m_valid ? m_inst : 32'h0, m_valid ? m_inst_pc : 32'h0};
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_ng    = 0;
        m_pc    = 32'h0;
        m_valid = 1'b0;
    endtask

    // One clock: update the model from this cycle's inputs, cross the edge,
    // then return the byte for any request the DUT had granted.
    task automatic advance();
        logic        g;
        logic [31:0] a;
        logic        exp_req;
        g       = mem_req && mem_gnt;
        a       = mem_addr;
        exp_req = (m_state == 1) && (m_ng < 4);
        if (jump) begin
            m_pc = jump_addr; m_state = 1; m_ng = 0; m_valid = 1'b0;
        end else begin
            case (m_state)
                0: begin m_state = 1; m_ng = 0; end
                1: begin
                    if (m_ng == 4) begin
                        m_state = 2; m_valid = 1'b1;
                        m_inst = word_at(m_pc); m_inst_pc = m_pc;
                    end else if (exp_req && mem_gnt) begin
                        m_ng++;
                    end
                end
                default: begin
                    if (id_ready) begin
                        m_pc = m_pc + 32'd4; m_state = 1; m_ng = 0; m_valid = 1'b0;
                    end
                end
            endcase
        end
        @(posedge clk);
        #1;
        mem_rdata = g ? mem_byte(a) : 8'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b0; jump = 1'b0; jump_addr = 32'h0; mem_gnt = 1'b1; id_ready = 1'b0;
        mem_rdata = 8'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({mem_req, mem_addr, inst_valid, inst, inst_pc} !== {1'b0, 32'h0, 1'b0, 32'h0, 32'h0}) begin
            failures++;
            $display("FAIL reset_values got req=%b addr=%h v=%b inst=%h pc=%h required all zero",
                     mem_req, mem_addr, inst_valid, inst, inst_pc);
        end
        rst = 1'b1;
    endtask

    task automatic test_first_fetch();
        int          entry = -1;
        int          lat   = -1;
        logic        done  = 1'b0;
        logic [31:0] a[$];
        mem_gnt = 1'b1; id_ready = 1'b0; jump = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL first_fetch cyc=%0d got=%h exp=%h", i, obs(), expv());
            end
            if (mem_req && entry < 0) entry = i;
            if (mem_req && mem_gnt) a.push_back(mem_addr);
            if (inst_valid) begin
                done = 1'b1;
                lat  = i - entry;
            end else begin
                advance();
            end
        end
        checks++;
        if (!done || lat != 5) begin
            failures++;
            $display("FAIL first_latency got=%0d required=5 (done=%0b)", lat, done);
        end
        checks++;
        if (a.size() != 4 || {a[0], a[1], a[2], a[3]} !== {32'd0, 32'd1, 32'd2, 32'd3}) begin
            failures++;
            $display("FAIL first_addrs count=%0d required 0,1,2,3", a.size());
        end
        checks++;
        if (inst !== 32'h0010_0513 || inst_pc !== 32'h0) begin
            failures++;
            $display("FAIL first_inst got=%h@%h required=00100513@00000000", inst, inst_pc);
        end
    endtask

    task automatic test_hold_stall();
        logic [31:0] si;
        logic [31:0] sp;
        si = inst; sp = inst_pc;
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs() !== expv() || inst !== si || inst_pc !== sp || mem_req !== 1'b0) begin
                failures++;
                $display("FAIL hold_stable cyc=%0d got=%h@%h req=%b required=%h@%h req=0",
                         i, inst, inst_pc, mem_req, si, sp);
            end
            advance();
        end
        id_ready = 1'b1;
        advance();
        id_ready = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'd4 || inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL after_accept got req=%b addr=%h v=%b required req=1 addr=4 v=0",
                     mem_req, mem_addr, inst_valid);
        end
    endtask

    task automatic test_gnt_deny();
        logic done = 1'b0;
        int   lat  = -1;
        for (int j = 0; j < 30 && !done; j++) begin
            mem_gnt = !(j == 2 || j == 3);
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL gnt_deny cyc=%0d got=%h exp=%h", j, obs(), expv());
            end
            if (j == 3) begin
                checks++;
                if (mem_req !== 1'b1 || mem_addr !== 32'd6) begin
                    failures++;
                    $display("FAIL deny_hold_addr got req=%b addr=%h required req=1 addr=6", mem_req, mem_addr);
                end
            end
            if (inst_valid) begin
                done = 1'b1; lat = j;
            end else begin
                advance();
            end
        end
        mem_gnt = 1'b1;
        checks++;
        if (!done || lat != 7 || inst !== word_at(32'd4) || inst_pc !== 32'd4) begin
            failures++;
            $display("FAIL deny_result lat=%0d inst=%h@%h required lat=7 inst=%h@4",
                     lat, inst, inst_pc, word_at(32'd4));
        end
        id_ready = 1'b1;
        advance();
        id_ready = 1'b0;
    endtask

    task automatic test_jump_outstanding();
        logic done = 1'b0;
        for (int j = 0; j < 30 && !done; j++) begin
            jump = (j == 2); jump_addr = 32'h100;
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL jump_out cyc=%0d got=%h exp=%h", j, obs(), expv());
            end
            if (j == 3) begin
                checks++;
                if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin
                    failures++;
                    $display("FAIL jump_first_addr got req=%b addr=%h required req=1 addr=00000100", mem_req, mem_addr);
                end
            end
            if (inst_valid && j > 2) done = 1'b1;
            else advance();
        end
        jump = 1'b0;
        checks++;
        if (!done || inst_pc !== 32'h100 || inst !== word_at(32'h100)) begin
            failures++;
            $display("FAIL jump_result got=%h@%h required=%h@00000100", inst, inst_pc, word_at(32'h100));
        end
    endtask

    task automatic test_jump_accept();
        id_ready = 1'b1; jump = 1'b1; jump_addr = 32'h200;
        checks++;
        if (inst_valid !== 1'b1) begin
            failures++;
            $display("FAIL jacc_pre got v=%b required v=1", inst_valid);
        end
        advance();
        id_ready = 1'b0; jump = 1'b0;
        checks++;
        if (inst_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h200) begin
            failures++;
            $display("FAIL jump_vs_accept got v=%b req=%b addr=%h required v=0 req=1 addr=00000200",
                     inst_valid, mem_req, mem_addr);
        end
    endtask

    task automatic test_wrap();
        logic        done = 1'b0;
        logic [31:0] a[$];
        jump = 1'b1; jump_addr = 32'hFFFF_FFFE;
        advance();
        jump = 1'b0;
        for (int j = 0; j < 30 && !done; j++) begin
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL wrap cyc=%0d got=%h exp=%h", j, obs(), expv());
            end
            if (mem_req && mem_gnt) a.push_back(mem_addr);
            if (inst_valid) done = 1'b1;
            else advance();
        end
        checks++;
        if (!done || a.size() != 4 ||
            {a[0], a[1], a[2], a[3]} !== {32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1} ||
            inst_pc !== 32'hFFFF_FFFE || inst !== word_at(32'hFFFF_FFFE)) begin
            failures++;
            $display("FAIL wrap_fetch got %0d addrs inst=%h@%h required 4 addrs inst=%h@fffffffe",
                     a.size(), inst, inst_pc, word_at(32'hFFFF_FFFE));
        end
        id_ready = 1'b1;
        advance();
        id_ready = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h2) begin
            failures++;
            $display("FAIL wrap_next_pc got req=%b addr=%h required req=1 addr=00000002", mem_req, mem_addr);
        end
    endtask

    task automatic test_random();
        int vcount = 0;
        for (int i = 0; i < 600; i++) begin
            mem_gnt   = ($urandom_range(0, 9) < 7);
            id_ready  = $urandom_range(0, 1) == 1;
            jump      = ($urandom_range(0, 39) == 0);
            jump_addr = $urandom;
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL random cyc=%0d got=%h exp=%h", i, obs(), expv());
            end
            if (inst_valid && id_ready && !jump) vcount++;
            advance();
        end
        jump = 1'b0; mem_gnt = 1'b1; id_ready = 1'b0;
        checks++;
        if (vcount < 10) begin
            failures++;
            $display("FAIL random_throughput got=%0d accepted required>=10", vcount);
        end
    endtask

    task automatic test_reset_mid();
        logic done = 1'b0;
        jump = 1'b1; jump_addr = 32'h300;
        advance();
        jump = 1'b0;
        advance();
        advance();
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({mem_req, mem_addr, inst_valid, inst, inst_pc} !== {1'b0, 32'h0, 1'b0, 32'h0, 32'h0}) begin
            failures++;
            $display("FAIL reset_mid got req=%b addr=%h v=%b inst=%h pc=%h required all zero",
                     mem_req, mem_addr, inst_valid, inst, inst_pc);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        mem_rdata = 8'($urandom);
        for (int j = 0; j < 30 && !done; j++) begin
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL after_reset cyc=%0d got=%h exp=%h", j, obs(), expv());
            end
            if (inst_valid) done = 1'b1;
            else advance();
        end
        checks++;
        if (!done || inst !== 32'h0010_0513 || inst_pc !== 32'h0) begin
            failures++;
            $display("FAIL refetch got=%h@%h required=00100513@00000000", inst, inst_pc);
        end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_hold_stall();
        test_gnt_deny();
        test_jump_outstanding();
        test_jump_accept();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
